// File: rtl/fpu_uart_cmd_frontend_if.sv
// rtl/fpu_uart_cmd_frontend_if.sv - frame issue / result handshake between the UART front end and the FPU
interface fpu_uart_cmd_frontend_if #(
    parameter int OP_W  = 32,
    parameter int N_OPS = 3
);
    logic                    fpu_valid_o;
    logic                    fpu_ready_i;
    logic [7:0]              fpu_opcode_o;
    logic [N_OPS*OP_W-1:0]   fpu_ops_o;
    logic                    fpu_done_i;
    logic [OP_W-1:0]         fpu_result_i;

    modport master (
        output fpu_valid_o, fpu_opcode_o, fpu_ops_o,
        input  fpu_ready_i, fpu_done_i, fpu_result_i
    );

    modport slave (
        input  fpu_valid_o, fpu_opcode_o, fpu_ops_o,
        output fpu_ready_i, fpu_done_i, fpu_result_i
    );
endinterface

// File: rtl/fpu_uart_cmd_frontend.sv
// rtl/fpu_uart_cmd_frontend.sv - UART 8N1 opcode+operand frame assembler feeding the FPU
// FPU_UART_TX_EN adds serial return of each captured result on tx_o.
module fpu_uart_cmd_frontend #(
    parameter int OP_W  = 32,
    parameter int N_OPS = 3,
    parameter int CPB_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic [CPB_W-1:0]         clks_per_bit,
    input  logic                     rx_i,
    fpu_uart_cmd_frontend_if.master  fpu,
    output logic [OP_W-1:0]          result_o,
    output logic                     busy_o,
    output logic                     frame_err_o,
    output logic                     overrun_o,
    output logic                     tx_o
);
    localparam int NB   = N_OPS * OP_W / 8;
    localparam int BC_W = $clog2(NB + 1);

    function automatic logic [CPB_W-1:0] clamp_div(input logic [CPB_W-1:0] d);
        return (d < CPB_W'(2)) ? CPB_W'(2) : d;
    endfunction

    typedef enum logic [1:0] {RX_WAIT, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE, S_OPS, S_ISSUE, S_WAIT
`ifdef FPU_UART_TX_EN
        , S_TX
`endif
    } state_t;

    rx_state_t         rx_state_q;
    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CPB_W-1:0]  rx_div_q, rx_cnt_q;
    logic [2:0]        rx_bit_q;
    logic [7:0]        rx_shift_q;
    logic              rx_byte_q, rx_ferr_q;
    logic              rx_tick;

    assign rx_tick = (rx_cnt_q == CPB_W'(1));

    // Counters run down to 1 so the start bit is re-checked D/2 clocks after the edge
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rx_state_q <= RX_WAIT;
            rx_meta_q  <= 1'b0;
            rx_sync_q  <= 1'b0;
            rx_prev_q  <= 1'b0;
            rx_div_q   <= '0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rx_byte_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            case (rx_state_q)
                RX_WAIT: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_div_q   <= clamp_div(clks_per_bit);
                        rx_cnt_q   <= clamp_div(clks_per_bit) >> 1;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        rx_cnt_q   <= rx_div_q;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? RX_WAIT : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - CPB_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_cnt_q   <= rx_div_q;
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - CPB_W'(1);
                    end
                end
                default: begin
                    if (rx_tick) begin
                        rx_byte_q  <= rx_sync_q;
                        rx_ferr_q  <= !rx_sync_q;
                        rx_state_q <= RX_WAIT;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - CPB_W'(1);
                    end
                end
            endcase
        end
    end

    state_t                state_q, state_d;
    logic [7:0]            opcode_q, opcode_d;
    logic [NB*8-1:0]       ops_q, ops_d;
    logic [BC_W-1:0]       bcnt_q, bcnt_d;
    logic [OP_W-1:0]       result_q, result_d;
    logic                  overrun_q, overrun_d;
    logic                  tx_finish;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            ops_q     <= '0;
            bcnt_q    <= '0;
            result_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            ops_q     <= ops_d;
            bcnt_q    <= bcnt_d;
            result_q  <= result_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        ops_d     = ops_q;
        bcnt_d    = bcnt_q;
        result_d  = result_q;
        overrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_byte_q) begin
                    opcode_d = rx_shift_q;
                    bcnt_d   = '0;
                    state_d  = S_OPS;
                end
            end
            S_OPS: begin
                if (rx_ferr_q) begin
                    state_d = S_IDLE;
                end else if (rx_byte_q) begin
                    ops_d[{bcnt_q, 3'b000} +: 8] = rx_shift_q;
                    bcnt_d = bcnt_q + BC_W'(1);
                    if (bcnt_q == BC_W'(NB - 1)) state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                overrun_d = rx_byte_q;
                if (fpu.fpu_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                overrun_d = rx_byte_q;
                if (fpu.fpu_done_i) begin
                    result_d = fpu.fpu_result_i;
`ifdef FPU_UART_TX_EN
                    state_d  = S_TX;
`else
                    state_d  = S_IDLE;
`endif
                end
            end
`ifdef FPU_UART_TX_EN
            S_TX: begin
                overrun_d = rx_byte_q;
                if (tx_finish) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifdef FPU_UART_TX_EN
    localparam int RB    = OP_W / 8;
    localparam int IDX_W = $clog2(RB + 1);

    logic [CPB_W-1:0]  tx_div_q, tx_cnt_q;
    logic [9:0]        tx_shift_q;
    logic [3:0]        tx_bit_q;
    logic [IDX_W-1:0]  tx_idx_q, tx_nidx;
    logic              tx_tick;

    assign tx_tick   = (tx_cnt_q == CPB_W'(1));
    assign tx_nidx   = tx_idx_q + IDX_W'(1);
    assign tx_finish = tx_tick && (tx_bit_q == 4'd9) && (tx_idx_q == IDX_W'(RB - 1));

    // Shift register holds {stop, data, start}; the next byte reloads right after a stop bit
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tx_div_q   <= '0;
            tx_cnt_q   <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_idx_q   <= '0;
        end else if (state_q == S_WAIT && fpu.fpu_done_i) begin
            tx_div_q   <= clamp_div(clks_per_bit);
            tx_cnt_q   <= clamp_div(clks_per_bit);
            tx_shift_q <= {1'b1, fpu.fpu_result_i[7:0], 1'b0};
            tx_bit_q   <= '0;
            tx_idx_q   <= '0;
        end else if (state_q == S_TX) begin
            if (tx_tick) begin
                tx_cnt_q <= tx_div_q;
                if (tx_bit_q == 4'd9) begin
                    if (tx_idx_q != IDX_W'(RB - 1)) begin
                        tx_idx_q   <= tx_nidx;
                        tx_shift_q <= {1'b1, result_q[{tx_nidx, 3'b000} +: 8], 1'b0};
                        tx_bit_q   <= '0;
                    end
                end else begin
                    tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                    tx_bit_q   <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q - CPB_W'(1);
            end
        end
    end

    assign tx_o = (state_q == S_TX) ? tx_shift_q[0] : 1'b1;
`else
    assign tx_finish = 1'b0;
    assign tx_o      = 1'b1;
`endif

    assign fpu.fpu_valid_o  = (state_q == S_ISSUE);
    assign fpu.fpu_opcode_o = opcode_q;
    assign fpu.fpu_ops_o    = ops_q;
    assign result_o         = result_q;
    assign busy_o           = (state_q != S_IDLE);
    assign frame_err_o      = rx_ferr_q;
    assign overrun_o        = overrun_q;
endmodule

// File: tb/tb_fpu_uart_cmd_frontend.sv
// tb/tb_fpu_uart_cmd_frontend.sv - directed scoreboard bench for fpu_uart_cmd_frontend
module tb_fpu_uart_cmd_frontend;
    localparam int OP_W  = 32;
    localparam int N_OPS = 3;
    localparam int CPB_W = 16;

    typedef struct {
        logic [7:0]  op;
        logic [95:0] ops;
    } frame_t;

    logic              clk = 1'b0;
    logic              rst_l = 1'b0;
    logic [CPB_W-1:0]  clks_per_bit = 16'd4;
    logic              rx_i = 1'b1;
    logic [OP_W-1:0]   result_o;
    logic              busy_o, frame_err_o, overrun_o, tx_o;

    fpu_uart_cmd_frontend_if #(.OP_W(OP_W), .N_OPS(N_OPS)) fif ();

    fpu_uart_cmd_frontend #(.OP_W(OP_W), .N_OPS(N_OPS), .CPB_W(CPB_W)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .clks_per_bit (clks_per_bit),
        .rx_i         (rx_i),
        .fpu          (fif),
        .result_o     (result_o),
        .busy_o       (busy_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .tx_o         (tx_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    frame_t      exp_q[$];
    logic [31:0] res_q[$];
    logic [31:0] last_res;

    always @(posedge clk) begin
        if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
        if (overrun_o)   ovr_cnt  <= ovr_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop, input int cpb);
        logic [9:0] f;
        f = {~bad_stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = f[i];
            cycles(cpb);
        end
        rx_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [95:0] ops,
                              input int bad_idx, input int cpb);
        send_byte(op, bad_idx == 0, cpb);
        for (int i = 1; i <= 12 && bad_idx != i - 1; i++)
            send_byte(ops[8*(i-1) +: 8], bad_idx == i, cpb);
    endtask

    task automatic expect_frame(input string tag);
        frame_t ef;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (fif.fpu_valid_o === 1'b1) seen = 1'b1;
            else cycles(1);
        end
        chk({tag, "_valid"}, seen, 1'b1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            ef = exp_q.pop_front();
            chk({tag, "_opcode"}, fif.fpu_opcode_o, ef.op);
            chk({tag, "_ops"}, fif.fpu_ops_o, ef.ops);
        end
    endtask

    task automatic accept();
        fif.fpu_ready_i = 1'b1;
        cycles(1);
        fif.fpu_ready_i = 1'b0;
    endtask

`ifdef FPU_UART_TX_EN
    task automatic recv_byte(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = '0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (tx_o === 1'b0) ok = 1'b1;
            else cycles(1);
        end
        cycles(2);
        for (int k = 0; k < 8; k++) begin
            cycles(4);
            b[k] = tx_o;
        end
        cycles(4);
    endtask
`endif

    task automatic finish_result(input string tag, input logic [31:0] r);
        logic [31:0] er;
        res_q.push_back(r);
        fif.fpu_done_i   = 1'b1;
        fif.fpu_result_i = r;
        cycles(1);
        fif.fpu_done_i   = 1'b0;
        fif.fpu_result_i = '0;
        er = res_q.pop_front();
        last_res = er;
        chk({tag, "_result"}, result_o, er);
`ifdef FPU_UART_TX_EN
        for (int k = 0; k < 4; k++) begin
            logic [7:0] rb;
            bit ok;
            recv_byte(rb, ok);
            chk({tag, "_tx_start"}, ok, 1'b1);
            chk({tag, "_tx_byte"}, rb, er[8*k +: 8]);
        end
        for (int i = 0; i < 20 && busy_o; i++) cycles(1);
`endif
        cycles(1);
        chk({tag, "_busy_idle"}, busy_o, 1'b0);
    endtask

    initial begin
        int fe0, ov0;
        fif.fpu_ready_i  = 1'b0;
        fif.fpu_done_i   = 1'b0;
        fif.fpu_result_i = '0;
        cycles(3);
        chk("rst_valid", fif.fpu_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_tx", tx_o, 1'b1);
        chk("rst_ferr", frame_err_o, 1'b0);
        chk("rst_ovr", overrun_o, 1'b0);
        rst_l = 1'b1;
        cycles(3);

        // basic frame, ready held low
        exp_q.push_back('{op: 8'h01, ops: 96'h00000000_40000000_3F800000});
        send_frame(8'h01, 96'h00000000_40000000_3F800000, -1, 4);
        expect_frame("t1");
        cycles(5);
        chk("t1_valid_held", fif.fpu_valid_o, 1'b1);
        chk("t1_ops_stable", fif.fpu_ops_o, 96'h00000000_40000000_3F800000);
        accept();
        chk("t2_valid_drop", fif.fpu_valid_o, 1'b0);
        chk("t2_busy_wait", busy_o, 1'b1);
        finish_result("t2", 32'h40400000);

        // done outside WAIT is ignored
        fif.fpu_done_i   = 1'b1;
        fif.fpu_result_i = 32'hDEADBEEF;
        cycles(1);
        fif.fpu_done_i   = 1'b0;
        cycles(1);
        chk("done_ignored", result_o, last_res);

        // stop bit low on 5th byte aborts the frame
        fe0 = ferr_cnt;
        send_frame(8'h07, 96'h11111111_22222222_33333333, 4, 4);
        cycles(6);
        chk("t3_ferr_pulses", ferr_cnt - fe0, 1);
        chk("t3_busy", busy_o, 1'b0);
        exp_q.push_back('{op: 8'h02, ops: 96'hC0000000_3F000000_12345678});
        send_frame(8'h02, 96'hC0000000_3F000000_12345678, -1, 4);
        expect_frame("t3");
        accept();
        finish_result("t3", 32'hBF800000);

        // byte during WAIT is an overrun
        exp_q.push_back('{op: 8'hA5, ops: 96'h01020304_A0B0C0D0_FFFFFFFF});
        send_frame(8'hA5, 96'h01020304_A0B0C0D0_FFFFFFFF, -1, 4);
        expect_frame("t4");
        accept();
        ov0 = ovr_cnt;
        send_byte(8'h55, 1'b0, 4);
        cycles(6);
        chk("t4_ovr_pulses", ovr_cnt - ov0, 1);
        chk("t4_busy", busy_o, 1'b1);
        chk("t4_valid", fif.fpu_valid_o, 1'b0);
        finish_result("t4", 32'h7F7FFFFF);

        // divisor below 2 runs at 2 clocks per bit
        clks_per_bit = 16'd1;
        exp_q.push_back('{op: 8'h3C, ops: 96'h89ABCDEF_76543210_00FF00FF});
        send_frame(8'h3C, 96'h89ABCDEF_76543210_00FF00FF, -1, 2);
        expect_frame("d2");
        accept();
        clks_per_bit = 16'd4;
        finish_result("d2", 32'h40400000);

        // reset during ISSUE
        exp_q.push_back('{op: 8'h09, ops: 96'h00000001_00000002_00000003});
        send_frame(8'h09, 96'h00000001_00000002_00000003, -1, 4);
        expect_frame("t6");
        #2;
        rst_l = 1'b0;
        #1;
        chk("t6_valid", fif.fpu_valid_o, 1'b0);
        chk("t6_tx", tx_o, 1'b1);
        chk("t6_result", result_o, 32'h0);
        chk("t6_busy", busy_o, 1'b0);
        cycles(2);
        rst_l = 1'b1;
        cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
